// File: rtl/hdmi_timing_gen.sv
// Video timing generator: hsync/vsync/de/pixel coordinates from free-running h/v counters,
// starting at a frame origin and stopping only at a frame boundary. Optional colour bars via HDMI_TESTPAT_EN.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        display_on,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic [23:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  logic [0:0]  state;
  logic [11:0] hcnt, vcnt;

  logic        h_act, v_act, hs_on, vs_on, h_wrap, v_wrap, active;
  logic [23:0] pix_rgb;

  assign h_act  = hcnt < 12'(H_ACTIVE);
  assign v_act  = vcnt < 12'(V_ACTIVE);
  assign hs_on  = ({1'b0, hcnt} >= HS_BEG) && ({1'b0, hcnt} < HS_END);
  assign vs_on  = ({1'b0, vcnt} >= VS_BEG) && ({1'b0, vcnt} < VS_END);
  assign h_wrap = hcnt == H_LAST;
  assign v_wrap = vcnt == V_LAST;
  assign active = h_act && v_act;

`ifdef HDMI_TESTPAT_EN
  // Bar index = hcnt*8/H_ACTIVE, found by threshold compare instead of a divider
  logic [2:0] bar;
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if ({hcnt, 3'b000} >= 15'(k * H_ACTIVE)) bar = 3'(k);
  end
  // White, yellow, cyan, green, magenta, red, blue, black fall out of the index bits
  assign pix_rgb = active ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h000000;
`else
  assign pix_rgb = 24'h000000;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_OFF;
      hcnt  <= 12'd0;
      vcnt  <= 12'd0;
    end else begin
      case (state)
        ST_OFF: begin
          hcnt <= 12'd0;
          vcnt <= 12'd0;
          if (display_on) state <= ST_RUN;
        end
        default: begin
          hcnt <= h_wrap ? 12'd0 : hcnt + 12'd1;
          if (h_wrap) vcnt <= v_wrap ? 12'd0 : vcnt + 12'd1;
          if (h_wrap && v_wrap && !display_on) state <= ST_OFF;
        end
      endcase
    end
  end

  // Outputs register the decode of the current counters; idle whenever not running
  always_ff @(posedge HCLK) begin
    if (HRESET || state == ST_OFF) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      frame_start <= 1'b0;
      rgb         <= 24'h000000;
    end else begin
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      de          <= active;
      pix_x       <= active ? hcnt : 12'd0;
      pix_y       <= active ? vcnt : 12'd0;
      frame_start <= (hcnt == 12'd0) && (vcnt == 12'd0);
      rgb         <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on an 8x6 raster: stimulus phase table, expectation segments
// pushed to a scoreboard queue, popped and compared once per clock.
module tb_hdmi_timing_gen;
  localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_ACTIVE = 3, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int LAST_CYC = 339;

  logic        HCLK = 1'b0;
  logic        HRESET, display_on;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] pix_x, pix_y;
  logic [23:0] rgb;

  always #5 HCLK = ~HCLK;

  hdmi_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .display_on(display_on),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .rgb(rgb)
  );

  typedef struct packed {
    logic        hs, vs, de, fs;
    logic [11:0] px, py;
    logic [23:0] rgb;
  } vid_t;
  typedef struct { int due; vid_t v; } exp_t;
  typedef struct { int at; bit don; bit rst; } stim_t;
  typedef struct { int start; bit frame; int len; } seg_t;
  typedef struct { bit act; bit hs; } hpos_t;
  typedef struct { bit act; bit vs; } vpos_t;

  exp_t        sbq[$];
  stim_t       stims[10];
  seg_t        segs[9];
  hpos_t       htab[8];
  vpos_t       vtab[6];
  logic [23:0] bars[8];

  int checks = 0, errors = 0, cyc = 0;
  int de_cnt = 0, vs_lo_cnt = 0, fs_cnt = 0;

  function automatic vid_t idle_v();
    vid_t v = '0;
    v.hs = 1'b1;
    v.vs = 1'b1;
    return v;
  endfunction

  // Expected output at offset o from a frame's first de (8 pixels per line)
  function automatic vid_t frame_v(int o);
    vid_t v = '0;
    int   px = o % 8, ln = o / 8;
    v.hs = htab[px].hs;
    v.vs = vtab[ln].vs;
    v.de = htab[px].act && vtab[ln].act;
    v.fs = (o == 0);
    if (v.de) begin
      v.px = 12'(px);
      v.py = 12'(ln);
`ifdef HDMI_TESTPAT_EN
      v.rgb = bars[(px * 8) / H_ACTIVE];
`endif
    end
    return v;
  endfunction

  task automatic check_cycle();
    vid_t act, e;
    act = {hsync, vsync, de, frame_start, pix_x, pix_y, rgb};
    checks++;
    if (sbq.size() == 0 || sbq[0].due != cyc) begin
      errors++;
      $display("FAIL scoreboard cyc=%0d: no expectation due (queue size %0d)", cyc, sbq.size());
    end else begin
      e = sbq.pop_front().v;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=%h want hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=%h",
                 cyc, act.hs, act.vs, act.de, act.fs, act.px, act.py, act.rgb,
                 e.hs, e.vs, e.de, e.fs, e.px, e.py, e.rgb);
      end
    end
  endtask

  task automatic check_count(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int p = 0;
    htab = '{'{1, 1}, '{1, 1}, '{1, 1}, '{1, 1}, '{0, 1}, '{0, 0}, '{0, 0}, '{0, 1}};
    vtab = '{'{1, 1}, '{1, 1}, '{1, 1}, '{0, 1}, '{0, 0}, '{0, 1}};
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Input changes take effect at the edge after the listed cycle
    stims = '{'{0, 0, 1}, '{3, 0, 0}, '{103, 1, 0}, '{160, 0, 0}, '{165, 1, 0},
              '{210, 0, 0}, '{260, 1, 0}, '{279, 1, 1}, '{280, 1, 0}, '{290, 0, 0}};

    // Output timeline: first de two edges after display_on is sampled; reset truncates at 280
    segs = '{'{1, 0, 104}, '{105, 1, 48}, '{153, 1, 48}, '{201, 1, 48}, '{249, 0, 13},
             '{262, 1, 18}, '{280, 0, 2}, '{282, 1, 48}, '{330, 0, 10}};

    foreach (segs[s])
      for (int i = 0; i < segs[s].len; i++)
        sbq.push_back('{due: segs[s].start + i, v: segs[s].frame ? frame_v(i) : idle_v()});

    HRESET     = 1'b1;
    display_on = 1'b0;
    while (cyc < LAST_CYC) begin
      if (p < 10 && stims[p].at == cyc) begin
        display_on = stims[p].don;
        HRESET     = stims[p].rst;
        p++;
      end
      @(posedge HCLK);
      #1;
      cyc++;
      check_cycle();
      if (de) de_cnt++;
      if (!vsync) vs_lo_cnt++;
      if (frame_start) fs_cnt++;
    end

    check_count("de_total", de_cnt, 4 * 12 + 10);
    check_count("vsync_low_total", vs_lo_cnt, 4 * 8);
    check_count("frame_start_total", fs_cnt, 5);
    check_count("scoreboard_leftover", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
